// File: rtl/best_idx_streamer_if.sv
`timescale 1ns/1ps
// Read-port and output-FIFO handshake bundle for best_idx_streamer.
// master = the streamer, slave = memory/consumer side.
interface best_idx_streamer_if #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 9
);
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_fifo_rempty_n;
    logic                  out_fifo_deq;
    logic [DATA_WIDTH-1:0] out_fifo_rdata;

    modport master (
        output mem_ren,
        output mem_raddr,
        input  mem_rdata,
        output out_fifo_rempty_n,
        output out_fifo_rdata,
        input  out_fifo_deq
    );

    modport slave (
        input  mem_ren,
        input  mem_raddr,
        output mem_rdata,
        input  out_fifo_rempty_n,
        input  out_fifo_rdata,
        output out_fifo_deq
    );
endinterface

// File: rtl/best_idx_streamer.sv
`timescale 1ns/1ps
// Streams the best-index memory in blocked host readout order (half-image,
// column block, row, in-block column) through a 2-entry credit-controlled FIFO.
module best_idx_streamer #(
    parameter int DATA_WIDTH = 11,
    parameter int ROW_SIZE   = 26,
    parameter int COL_SIZE   = 19,
    parameter int BLOCKING   = 4,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
    input  logic                io_clk,
    input  logic                io_rst_n,
    input  logic                send_best_arr,
    best_idx_streamer_if.master bus,
    output logic                busy,
    output logic                done
);
    localparam int HALF = ROW_SIZE / 2;
    localparam int NB   = (HALF + BLOCKING - 1) / BLOCKING;
    localparam int XW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int YW   = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
    localparam int IW   = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;
    localparam int CW   = $clog2(NUM_QUERYS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_reg;
    logic                  px_reg;
    logic [XW-1:0]         x_reg;
    logic [YW-1:0]         y_reg;
    logic [IW-1:0]         xi_reg;
    logic [CW-1:0]         issued_reg;
    logic [CW-1:0]         popped_reg;
    logic                  mem_ren_reg;
    logic                  pend_reg;
    logic [ADDR_WIDTH-1:0] mem_raddr_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            count_reg;

    logic                  base_px;
    logic [XW-1:0]         base_x;
    logic [YW-1:0]         base_y;
    logic [IW-1:0]         base_xi;
    logic                  px_next;
    logic [XW-1:0]         x_next;
    logic [YW-1:0]         y_next;
    logic [IW-1:0]         xi_next;
    logic [31:0]           addr_full;
    logic                  last_xi;
    logic                  wr;
    logic                  pop;
    logic [1:0]            count_after;
    logic                  credit_ok;
    logic                  gen_left;
    logic                  issue;
    logic                  last_pop;

    // Generation starts from the all-zero combination when idle, so the first
    // read can be issued on the very edge that samples the start pulse.
    always_comb begin
        base_px = px_reg;
        base_x  = x_reg;
        base_y  = y_reg;
        base_xi = xi_reg;
        if (state_reg == IDLE) begin
            base_px = 1'b0;
            base_x  = '0;
            base_y  = '0;
            base_xi = '0;
        end

        addr_full = 32'(base_px) * 32'(HALF) + 32'(base_y) * 32'(ROW_SIZE)
                  + 32'(base_x) * 32'(BLOCKING) + 32'(base_xi);

        // Columns beyond the half-image edge are skipped by jumping straight to
        // the next row, which is always legal because xi=0 is inside the image.
        last_xi = (base_xi == IW'(BLOCKING - 1))
               || (32'(base_x) * 32'(BLOCKING) + 32'(base_xi) + 32'd1 >= 32'(HALF));

        px_next = base_px;
        x_next  = base_x;
        y_next  = base_y;
        xi_next = base_xi + IW'(1);
        if (last_xi) begin
            xi_next = '0;
            if (base_y == YW'(COL_SIZE - 1)) begin
                y_next = '0;
                if (base_x == XW'(NB - 1)) begin
                    x_next  = '0;
                    px_next = ~base_px;
                end else begin
                    x_next = base_x + XW'(1);
                end
            end else begin
                y_next = base_y + YW'(1);
            end
        end

        wr          = pend_reg;
        pop         = bus.out_fifo_deq && (count_reg != 2'd0);
        count_after = count_reg + {1'b0, wr} - {1'b0, pop};
        // Occupancy after this edge plus the read on the bus must leave room.
        credit_ok   = (count_after + {1'b0, mem_ren_reg}) < 2'd2;
        gen_left    = (issued_reg != CW'(NUM_QUERYS));
        issue       = ((state_reg == IDLE) && send_best_arr)
                   || ((state_reg == RUN) && gen_left && credit_ok);
        last_pop    = (state_reg == RUN) && pop && (popped_reg == CW'(NUM_QUERYS - 1));
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state_reg     <= IDLE;
            px_reg        <= 1'b0;
            x_reg         <= '0;
            y_reg         <= '0;
            xi_reg        <= '0;
            issued_reg    <= '0;
            popped_reg    <= '0;
            mem_ren_reg   <= 1'b0;
            pend_reg      <= 1'b0;
            mem_raddr_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            pend_reg    <= mem_ren_reg;
            mem_ren_reg <= issue;
            if (issue) begin
                mem_raddr_reg <= addr_full[ADDR_WIDTH-1:0];
                px_reg        <= px_next;
                x_reg         <= x_next;
                y_reg         <= y_next;
                xi_reg        <= xi_next;
            end
            case (state_reg)
                IDLE: begin
                    if (send_best_arr) begin
                        state_reg  <= RUN;
                        busy_reg   <= 1'b1;
                        done_reg   <= 1'b0;
                        issued_reg <= CW'(1);
                        popped_reg <= '0;
                    end
                end
                RUN: begin
                    if (issue) issued_reg <= issued_reg + CW'(1);
                    if (pop)   popped_reg <= popped_reg + CW'(1);
                    if (last_pop) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (wr)  wr_ptr_reg <= ~wr_ptr_reg;
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_after;
        end
    end

    logic [DATA_WIDTH-1:0] entry_data [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [DATA_WIDTH-1:0] entry_reg;
        always_ff @(posedge io_clk or negedge io_rst_n) begin
            if (!io_rst_n) begin
                entry_reg <= '0;
            end else if (wr && (wr_ptr_reg == 1'(gi))) begin
                entry_reg <= bus.mem_rdata;
            end
        end
        assign entry_data[gi] = entry_reg;
    end

    assign bus.mem_ren           = mem_ren_reg;
    assign bus.mem_raddr         = mem_raddr_reg;
    assign bus.out_fifo_rempty_n = (count_reg != 2'd0);
    assign bus.out_fifo_rdata    = entry_data[rd_ptr_reg];
    assign busy                  = busy_reg;
    assign done                  = done_reg;
endmodule

// File: tb/tb_best_idx_streamer.sv
`timescale 1ns/1ps
// Bench for best_idx_streamer: default geometry under several consumer patterns
// plus a small odd geometry, checked against a loop-built readout-order model.
module tb_best_idx_streamer;
    localparam int DW  = 11;
    localparam int RA  = 26;
    localparam int CA  = 19;
    localparam int BA  = 4;
    localparam int NA  = RA * CA;
    localparam int AWA = $clog2(NA);
    localparam int RB  = 10;
    localparam int CB  = 3;
    localparam int BB  = 4;
    localparam int NQB = RB * CB;
    localparam int AWB = $clog2(NQB);

    typedef int iq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, start_a, start_b;
    logic busy_a, done_a, busy_b, done_b;

    best_idx_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWA)) if_a ();
    best_idx_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWB)) if_b ();

    best_idx_streamer #(.DATA_WIDTH(DW), .ROW_SIZE(RA), .COL_SIZE(CA), .BLOCKING(BA)) dut_a (
        .io_clk(clk), .io_rst_n(rst_a), .send_best_arr(start_a),
        .bus(if_a.master), .busy(busy_a), .done(done_a)
    );
    best_idx_streamer #(.DATA_WIDTH(DW), .ROW_SIZE(RB), .COL_SIZE(CB), .BLOCKING(BB)) dut_b (
        .io_clk(clk), .io_rst_n(rst_b), .send_best_arr(start_b),
        .bus(if_b.master), .busy(busy_b), .done(done_b)
    );

    logic [DW-1:0] mem_a [NA];
    logic [DW-1:0] mem_b [NQB];

    // Synchronous memories: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (if_a.mem_ren) if_a.mem_rdata <= mem_a[int'(if_a.mem_raddr)];
        if (if_b.mem_ren) if_b.mem_rdata <= mem_b[int'(if_b.mem_raddr)];
    end

    int compared   = 0;
    int mismatched = 0;
    iq_t ord_a, ord_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Readout order straight from the nesting rules, skipping off-image columns.
    function automatic iq_t build_order(input int r, input int c, input int b);
        iq_t q;
        int half = r / 2;
        int nb = (half + b - 1) / b;
        for (int px = 0; px < 2; px++)
            for (int x = 0; x < nb; x++)
                for (int y = 0; y < c; y++)
                    for (int xi = 0; xi < b; xi++)
                        if (x * b + xi < half) q.push_back(px * half + y * r + x * b + xi);
        return q;
    endfunction

    task automatic check_a_zero(input string tag);
        check({tag, "_ren"},     if_a.mem_ren, 0);
        check({tag, "_raddr"},   if_a.mem_raddr, 0);
        check({tag, "_rempty"},  if_a.out_fifo_rempty_n, 0);
        check({tag, "_rdata"},   if_a.out_fifo_rdata, 0);
        check({tag, "_busy"},    busy_a, 0);
        check({tag, "_done"},    done_a, 0);
    endtask

    task automatic run_a(input int pct, input int start_at, input int abort_at, input string tag);
        int popped = 0;
        int issued = 0;
        int cyc = 0;
        bit fin = 0;
        bit pulsed = 0;
        bit pop = 0;
        bit prev_hold = 0;
        logic [DW-1:0] prev_data = '0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check({tag, "_first_ren"},  if_a.mem_ren, 1);
        check({tag, "_first_addr"}, if_a.mem_raddr, 0);
        check({tag, "_busy_rise"},  busy_a, 1);
        check({tag, "_done_clr"},   done_a, 0);
        while (!fin && cyc < 40 * NA) begin
            if (if_a.mem_ren) issued++;
            check({tag, "_credit"}, 32'((issued - popped) <= 2), 1);
            if (prev_hold) check({tag, "_hold"}, if_a.out_fifo_rdata, prev_data);
            if_a.out_fifo_deq = ($urandom_range(99) < pct);
            start_a = (!pulsed && start_at >= 0 && popped == start_at);
            if (start_a) pulsed = 1;
            pop = if_a.out_fifo_rempty_n && if_a.out_fifo_deq;
            if (pop) begin
                check($sformatf("%s_word%0d", tag, popped), if_a.out_fifo_rdata, mem_a[ord_a[popped]]);
                $display("%s pop %0d data %0d", tag, popped, if_a.out_fifo_rdata);
                popped++;
            end
            prev_hold = if_a.out_fifo_rempty_n && !pop;
            prev_data = if_a.out_fifo_rdata;
            @(negedge clk);
            cyc++;
            if (pop && popped == NA) begin
                check({tag, "_done_rise"}, done_a, 1);
                check({tag, "_busy_fall"}, busy_a, 0);
                fin = 1;
            end else begin
                check({tag, "_busy_run"}, busy_a, 1);
                if (abort_at >= 0 && popped == abort_at) fin = 1;
            end
        end
        if_a.out_fifo_deq = 1'b0;
        start_a = 1'b0;
        if (abort_at < 0) begin
            check({tag, "_count"}, popped, NA);
            check({tag, "_empty_after"}, if_a.out_fifo_rempty_n, 0);
            @(negedge clk);
            check({tag, "_no_extra_ren"}, if_a.mem_ren, 0);
            check({tag, "_done_held"}, done_a, 1);
        end else begin
            check({tag, "_abort_count"}, popped, abort_at);
        end
    endtask

    task automatic run_b(input string tag);
        int popped = 0;
        int cyc = 0;
        bit fin = 0;
        bit pop = 0;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        if_b.out_fifo_deq = 1'b1;
        while (!fin && cyc < 40 * NQB) begin
            pop = if_b.out_fifo_rempty_n;
            if (pop) begin
                check($sformatf("%s_word%0d", tag, popped), if_b.out_fifo_rdata, mem_b[ord_b[popped]]);
                $display("%s pop %0d data %0d", tag, popped, if_b.out_fifo_rdata);
                popped++;
            end
            @(negedge clk);
            cyc++;
            if (pop && popped == NQB) begin
                check({tag, "_done_rise"}, done_b, 1);
                check({tag, "_busy_fall"}, busy_b, 0);
                fin = 1;
            end
        end
        if_b.out_fifo_deq = 1'b0;
        check({tag, "_count"}, popped, NQB);
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        if_a.out_fifo_deq = 1'b0;
        if_b.out_fifo_deq = 1'b0;
        ord_a = build_order(RA, CA, BA);
        ord_b = build_order(RB, CB, BB);
        for (int i = 0; i < NA; i++) mem_a[i] = DW'(i);
        for (int i = 0; i < NQB; i++) mem_b[i] = DW'(i);

        #1;
        check_a_zero("reset");
        check("reset_b_rempty", if_b.out_fifo_rempty_n, 0);
        check("reset_b_busy", busy_b, 0);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.out_fifo_deq = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_deq_rempty", if_a.out_fifo_rempty_n, 0);
        check("idle_deq_ren", if_a.mem_ren, 0);
        if_a.out_fifo_deq = 1'b0;

        run_a(100, -1, -1, "full");

        for (int i = 0; i < NA; i++) mem_a[i] = DW'($urandom);
        run_a(30, -1, -1, "bp30");

        run_a(70, 100, -1, "busy_start");

        for (int i = 0; i < NA; i++) mem_a[i] = DW'(i);
        run_a(60, -1, 200, "pre_reset");
        rst_a = 1'b0;
        #1;
        check_a_zero("mid_reset");
        @(negedge clk);
        check("mid_reset_hold_rempty", if_a.out_fifo_rempty_n, 0);
        check("mid_reset_hold_busy", busy_a, 0);
        rst_a = 1'b1;
        run_a(100, -1, -1, "restart");

        run_b("odd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
